fll_if_responder: RTL



---
 rtl/fll_if_pkg.sv | 36 +++
 rtl/fll_if_responder_if.sv | 12 +
 rtl/fll_lock_timer.sv | 45 ++++
 rtl/fll_sync2.sv | 23 ++
 rtl/fll_if_responder.sv | 127 ++++++++++++
 5 files changed

// File: rtl/fll_if_pkg.sv
// Shared definitions for the FLL configuration-bus responder: register
// addresses, CFG1 field layout, INTEG write mask and default reset values.
package fll_if_pkg;

   localparam logic [1:0] FLL_ADDR_STATUS = 2'd0;
   localparam logic [1:0] FLL_ADDR_CFG1   = 2'd1;
   localparam logic [1:0] FLL_ADDR_CFG2   = 2'd2;
   localparam logic [1:0] FLL_ADDR_INTEG  = 2'd3;

   // Only the integrator field [25:16] of INTEG is implemented.
   localparam logic [31:0] FLL_INTEG_MASK = 32'h03FF_0000;

   localparam int unsigned FLL_LOCK_CYCLES_DEF = 64;
   localparam logic [31:0] FLL_CFG1_RST_DEF    = 32'h0000_05F5;
   localparam logic [31:0] FLL_CFG2_RST_DEF    = 32'h0000_0002;
   localparam logic [31:0] FLL_INTEG_RST_DEF   = 32'h0000_0000;

   typedef struct packed {
      logic        mode;   // [31]
      logic        rsvd;   // [30]
      logic [3:0]  div;    // [29:26]
      logic [9:0]  dco;    // [25:16]
      logic [15:0] mult;   // [15:0]
   } fll_cfg1_t;

   typedef enum logic {
      FSM_IDLE = 1'b0,
      FSM_ACK  = 1'b1
   } fll_fsm_e;

   // STATUS word: current multiplier in the low half, lock flag at bit 16.
   function automatic logic [31:0] fll_status(fll_cfg1_t cfg1, logic lock);
      return {15'b0, lock, cfg1.mult};
   endfunction

endpackage

// File: rtl/fll_if_responder_if.sv
// FLL configuration bus: 4-phase req/ack with bundled command and data.
interface fll_if_responder_if;
   logic        req;
   logic        wrn;    // 1 = read, 0 = write
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, wrn, addr, wdata, input ack, rdata);
   modport slave  (input req, wrn, addr, wdata, output ack, rdata);
endinterface

// File: rtl/fll_lock_timer.sv
// Lock settle timer: counts LOCK_CYCLES down after reset or restart and
// raises lock once the count expires. A restart always wins over expiry.
module fll_lock_timer #(
   parameter int unsigned LOCK_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic restart_i,
   output logic lock_o
);
   localparam int unsigned CW = $clog2(LOCK_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(LOCK_CYCLES);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          lock_q, lock_d;

   // Next-state: reload on restart, otherwise count down and lock on 1 -> 0.
   always_comb begin
      cnt_d  = cnt_q;
      lock_d = lock_q;
      if (restart_i) begin
         cnt_d  = LOAD;
         lock_d = 1'b0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
         if (cnt_q == ONE) begin
            lock_d = 1'b1;
         end
      end
   end

   // Counter and lock flag registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= LOAD;
         lock_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lock_q <= lock_d;
      end
   end

   assign lock_o = lock_q;
endmodule

// File: rtl/fll_sync2.sv
// Two-flop synchroniser for a single-bit level crossing into clk_i.
module fll_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   // Shift the asynchronous level through two flops to resolve metastability.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/fll_if_responder.sv
// Target-side endpoint of the FLL configuration bus. Synchronises the
// incoming request, performs one register access per 4-phase handshake
// and exposes the configuration fields plus a lock indication.
module fll_if_responder
   import fll_if_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = FLL_LOCK_CYCLES_DEF,
   parameter logic [31:0] CFG1_RST    = FLL_CFG1_RST_DEF,
   parameter logic [31:0] CFG2_RST    = FLL_CFG2_RST_DEF,
   parameter logic [31:0] INTEG_RST   = FLL_INTEG_RST_DEF
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   fll_if_responder_if.slave   bus,
   output logic                lock_o,
   output logic [15:0]         mult_o,
   output logic [3:0]          div_o,
   output logic [31:0]         cfg2_o
);
   logic        req_s;
   logic        lock;
   logic        cfg1_wr;
   logic [31:0] rd_mux;

   fll_fsm_e    state_q, state_d;
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;
   fll_cfg1_t   cfg1_q, cfg1_d;
   logic [31:0] cfg2_q, cfg2_d;
   logic [31:0] integ_q, integ_d;

   // Only req crosses domains; command and data are bundled and held stable.
   fll_sync2 u_req_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (bus.req),
      .q_o   (req_s)
   );

   fll_lock_timer #(
      .LOCK_CYCLES(LOCK_CYCLES)
   ) u_lock_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .restart_i(cfg1_wr),
      .lock_o   (lock)
   );

   // Register read multiplexer (INTEG is stored already masked).
   always_comb begin
      rd_mux = '0;
      case (bus.addr)
         FLL_ADDR_STATUS: rd_mux = fll_status(cfg1_q, lock);
         FLL_ADDR_CFG1:   rd_mux = cfg1_q;
         FLL_ADDR_CFG2:   rd_mux = cfg2_q;
         default:         rd_mux = integ_q;
      endcase
   end

   // Handshake FSM: one access on entry to ACK, then wait for req to drop.
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      rdata_d = rdata_q;
      cfg1_d  = cfg1_q;
      cfg2_d  = cfg2_q;
      integ_d = integ_q;
      cfg1_wr = 1'b0;
      case (state_q)
         FSM_IDLE: begin
            if (req_s) begin
               state_d = FSM_ACK;
               ack_d   = 1'b1;
               if (bus.wrn) begin
                  rdata_d = rd_mux;
               end else begin
                  case (bus.addr)
                     FLL_ADDR_CFG1: begin
                        cfg1_d  = fll_cfg1_t'(bus.wdata);
                        cfg1_wr = 1'b1;
                     end
                     FLL_ADDR_CFG2:  cfg2_d  = bus.wdata;
                     FLL_ADDR_INTEG: integ_d = bus.wdata & FLL_INTEG_MASK;
                     default: ;  // STATUS is read-only; write is acknowledged only
                  endcase
               end
            end
         end
         FSM_ACK: begin
            if (!req_s) begin
               state_d = FSM_IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = FSM_IDLE;
            ack_d   = 1'b0;
         end
      endcase
   end

   // State, handshake outputs and configuration registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= FSM_IDLE;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         cfg1_q  <= fll_cfg1_t'(CFG1_RST);
         cfg2_q  <= CFG2_RST;
         integ_q <= INTEG_RST & FLL_INTEG_MASK;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         cfg1_q  <= cfg1_d;
         cfg2_q  <= cfg2_d;
         integ_q <= integ_d;
      end
   end

   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign lock_o    = lock;
   assign mult_o    = cfg1_q.mult;
   assign div_o     = cfg1_q.div;
   assign cfg2_o    = cfg2_q;
endmodule
